// File: rtl/tdc_spi_arbiter_if.sv
// rtl/tdc_spi_arbiter_if.sv - start/MOSI/CS_END/busy/MISO handshake bundle, N ports wide
interface tdc_spi_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   start;
  logic [8*N-1:0] mosi;
  logic [N-1:0]   cs_end;
  logic [N-1:0]   busy;
  logic [7:0]     miso;

  modport master (output start, output mosi, output cs_end, input busy, input miso);
  modport slave  (input start, input mosi, input cs_end, output busy, output miso);
endinterface

// File: rtl/tdc_spi_arbiter.sv
// rtl/tdc_spi_arbiter.sv - round-robin SPI master sharing for TDC controllers; HOLD timeout under TDC_ARB_TIMEOUT_EN
module tdc_spi_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PTR_W        = 2,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tdc_spi_arbiter_if.slave     req_if,
  tdc_spi_arbiter_if.master    spi_if,
  output logic                 overrun,
  output logic                 frame_abort
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]         req_miso_q, req_miso_d;
  logic [NUM_REQ-1:0] pend_valid_q, pend_valid_d;
  logic [NUM_REQ-1:0] pend_cs_end_q;
  logic [7:0]         pend_byte_q [NUM_REQ];
  logic               overrun_q;
  logic [NUM_REQ-1:0] clr, accept, ovr;
  logic               sel_found;
  logic [PTR_W-1:0]   sel_idx;
  logic               active;

  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << PTR_W) < NUM_REQ ||
      HOLD_TIMEOUT < 1 || HOLD_TIMEOUT > 255) begin : g_bad_cfg
    $error("tdc_spi_arbiter: illegal parameter combination");
  end

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // First pending requester at or after rr_ptr, wrapping at NUM_REQ
  always_comb begin
    int idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!sel_found && pend_valid_q[PTR_W'(idx)]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(idx);
      end
    end
  end

`ifdef TDC_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       abort_d, frame_abort_q;
`endif

  // Frame FSM: next state, owner, round-robin pointer and pending-clear strobe
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    req_miso_d = req_miso_q;
    clr        = '0;
`ifdef TDC_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    abort_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          owner_d = sel_idx;
          state_d = ISSUE;
        end
      end
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (spi_if.busy[0]) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!spi_if.busy[0]) begin
          req_miso_d = spi_if.miso;
          clr        = NUM_REQ'(1) << owner_q;
          if (pend_cs_end_q[owner_q]) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr(owner_q);
          end else begin
            state_d  = HOLD;
`ifdef TDC_ARB_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end
        end
      end
      HOLD: begin
        if (pend_valid_q[owner_q]) begin
          state_d = ISSUE;
        end
`ifdef TDC_ARB_TIMEOUT_EN
        else if (cnt_q == 8'(HOLD_TIMEOUT)) begin
          abort_d  = 1'b1;
          rr_ptr_d = next_ptr(owner_q);
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending buffer: owner's clear lands first so a same-cycle start is still accepted
  always_comb begin
    accept       = req_if.start & (~pend_valid_q | clr);
    ovr          = req_if.start & pend_valid_q & ~clr;
    pend_valid_d = (pend_valid_q & ~clr) | accept;
  end

  // FSM and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      req_miso_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      req_miso_q <= req_miso_d;
      overrun_q  <= |ovr;
    end
  end

  // Per-requester one-byte buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q  <= '0;
      pend_cs_end_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) pend_byte_q[i] <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          pend_byte_q[i]   <= req_if.mosi[8*i +: 8];
          pend_cs_end_q[i] <= req_if.cs_end[i];
        end
      end
    end
  end

`ifdef TDC_ARB_TIMEOUT_EN
  // HOLD idle counter and abort pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      frame_abort_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      frame_abort_q <= abort_d;
    end
  end
  assign frame_abort = frame_abort_q;
`else
  assign frame_abort = 1'b0;
`endif

  // Owner's byte is presented from ISSUE until the busy fall is consumed
  assign active         = (state_q == ISSUE) || (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  assign spi_if.start   = (state_q == ISSUE);
  assign spi_if.mosi    = active ? pend_byte_q[owner_q] : 8'h00;
  assign spi_if.cs_end  = active & pend_cs_end_q[owner_q];
  assign req_if.busy    = pend_valid_q;
  assign req_if.miso    = req_miso_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_tdc_spi_arbiter.sv
// tb/tb_tdc_spi_arbiter.sv - directed self-checking bench for tdc_spi_arbiter
module tb_tdc_spi_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic overrun, frame_abort;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] log_mosi [$];
  logic       log_cse  [$];
  logic [7:0] miso_q   [$];

  always #5 clk = ~clk;

  tdc_spi_arbiter_if #(.N(4)) req_bus ();
  tdc_spi_arbiter_if #(.N(1)) spi_bus ();

  tdc_spi_arbiter #(.NUM_REQ(4), .PTR_W(2), .HOLD_TIMEOUT(255)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_if      (req_bus),
    .spi_if      (spi_bus),
    .overrun     (overrun),
    .frame_abort (frame_abort)
  );

  // SPI master model: logs each started byte, busy for 3 edges, then returns next MISO
  initial begin
    spi_bus.busy = 1'b0;
    spi_bus.miso = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (spi_bus.start[0]) begin
        log_mosi.push_back(spi_bus.mosi);
        log_cse.push_back(spi_bus.cs_end[0]);
        spi_bus.busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        spi_bus.miso = (miso_q.size() > 0) ? miso_q.pop_front() : 8'hEE;
        spi_bus.busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send_multi(input logic [3:0] mask, input logic [31:0] bytes, input logic [3:0] ce);
    req_bus.start  = mask;
    req_bus.mosi   = bytes;
    req_bus.cs_end = ce;
    tick();
    req_bus.start  = 4'b0000;
  endtask

  task automatic send(input int i, input logic [7:0] b, input logic ce);
    logic [3:0]  m;
    logic [31:0] d;
    logic [3:0]  c;
    m = 4'b0000; d = 32'h0; c = 4'b0000;
    m[i] = 1'b1; d[8*i +: 8] = b; c[i] = ce;
    send_multi(m, d, c);
  endtask

  task automatic wait_busy_low(input int i, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (!req_bus.busy[i]) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_quiet(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (req_bus.busy == 4'b0000 && !spi_bus.busy[0]) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic apply_reset();
    req_bus.start = 4'b0000; req_bus.mosi = 32'h0; req_bus.cs_end = 4'b0000;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    req_bus.start = 4'b0000; req_bus.mosi = 32'h0; req_bus.cs_end = 4'b0000;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (req_bus.busy !== 4'b0000 || req_bus.miso !== 8'h00) begin
      n_fail++; $display("FAIL reset_req: busy=%b miso=%h want 0000/00", req_bus.busy, req_bus.miso);
    end
    n_tests++;
    if (spi_bus.start !== 1'b0 || spi_bus.mosi !== 8'h00 || spi_bus.cs_end !== 1'b0) begin
      n_fail++; $display("FAIL reset_spi: start=%b mosi=%h cs_end=%b want 0/00/0", spi_bus.start, spi_bus.mosi, spi_bus.cs_end);
    end
    n_tests++;
    if (overrun !== 1'b0 || frame_abort !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: overrun=%b frame_abort=%b want 0/0", overrun, frame_abort);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    int base; bit ok;
    base = log_mosi.size();
    miso_q.push_back(8'h11); miso_q.push_back(8'h22);
    send(0, 8'hA5, 1'b0);
    n_tests++;
    if (req_bus.busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL t1_busy_rise: got %b want 1", req_bus.busy[0]);
    end
    tick();
    n_tests++;
    if (spi_bus.start[0] !== 1'b1 || spi_bus.mosi !== 8'hA5 || spi_bus.cs_end[0] !== 1'b0) begin
      n_fail++; $display("FAIL t1_issue: start=%b mosi=%h cs_end=%b want 1/a5/0", spi_bus.start, spi_bus.mosi, spi_bus.cs_end);
    end
    wait_busy_low(0, ok);
    n_tests++;
    if (!ok || req_bus.miso !== 8'h11) begin
      n_fail++; $display("FAIL t1_first_byte: done=%0d miso=%h want 1/11", ok, req_bus.miso);
    end
    send(0, 8'h3C, 1'b1);
    wait_quiet(ok);
    n_tests++;
    if (!ok || log_mosi.size() != base + 2) begin
      n_fail++; $display("FAIL t1_count: done=%0d bytes=%0d want 1/%0d", ok, log_mosi.size(), base + 2);
    end else begin
      n_tests++;
      if (log_mosi[base] !== 8'hA5 || log_cse[base] !== 1'b0 || log_mosi[base+1] !== 8'h3C || log_cse[base+1] !== 1'b1) begin
        n_fail++; $display("FAIL t1_bytes: got %h/%b %h/%b want a5/0 3c/1",
                           log_mosi[base], log_cse[base], log_mosi[base+1], log_cse[base+1]);
      end
    end
    n_tests++;
    if (req_bus.miso !== 8'h22) begin
      n_fail++; $display("FAIL t1_miso: got %h want 22", req_bus.miso);
    end
  endtask

  task automatic test_round_robin();
    int base; bit ok;
    apply_reset();
    base = log_mosi.size();
    send_multi(4'b0110, 32'h00C2_B100, 4'b0110);
    wait_quiet(ok);
    n_tests++;
    if (!ok || log_mosi.size() != base + 2 || log_mosi[base] !== 8'hB1 || log_mosi[base+1] !== 8'hC2) begin
      n_fail++; $display("FAIL t2_order12: done=%0d bytes=%0d want req1 b1 then req2 c2", ok, log_mosi.size() - base);
    end
    base = log_mosi.size();
    send_multi(4'b1001, 32'hD300_00E0, 4'b1001);
    wait_quiet(ok);
    n_tests++;
    if (!ok || log_mosi.size() != base + 2 || log_mosi[base] !== 8'hD3 || log_mosi[base+1] !== 8'hE0) begin
      n_fail++; $display("FAIL t2_rr_ptr3: done=%0d bytes=%0d want req3 d3 then req0 e0", ok, log_mosi.size() - base);
    end
  endtask

  task automatic test_frame_lock();
    int base; bit ok;
    base = log_mosi.size();
    send(0, 8'h40, 1'b0);
    wait_busy_low(0, ok);
    send(3, 8'h43, 1'b1);
    repeat (20) tick();
    n_tests++;
    if (!ok || log_mosi.size() != base + 1 || req_bus.busy[3] !== 1'b1) begin
      n_fail++; $display("FAIL t3_locked: bytes=%0d busy3=%b want 1/1", log_mosi.size() - base, req_bus.busy[3]);
    end
    send(0, 8'h41, 1'b1);
    wait_quiet(ok);
    n_tests++;
    if (!ok || log_mosi.size() != base + 3 || log_mosi[base+1] !== 8'h41 || log_mosi[base+2] !== 8'h43) begin
      n_fail++; $display("FAIL t3_release: done=%0d bytes=%0d want 40 41 43", ok, log_mosi.size() - base);
    end
  endtask

  task automatic test_overrun();
    int base; bit ok;
    base = log_mosi.size();
    send(2, 8'h52, 1'b1);
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL t4_no_overrun: got %b want 0", overrun);
    end
    send(2, 8'h99, 1'b1);
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++; $display("FAIL t4_overrun_pulse: got %b want 1", overrun);
    end
    tick();
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL t4_overrun_width: got %b want 0", overrun);
    end
    wait_quiet(ok);
    n_tests++;
    if (!ok || log_mosi.size() != base + 1 || log_mosi[base] !== 8'h52) begin
      n_fail++; $display("FAIL t4_dropped: done=%0d bytes=%0d want single 52", ok, log_mosi.size() - base);
    end
  endtask

`ifdef TDC_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int base; int n; bit ok;
    send(0, 8'h50, 1'b0);
    wait_busy_low(0, ok);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      tick(); n++;
      if (frame_abort) break;
    end
    n_tests++;
    if (!ok || n != 256) begin
      n_fail++; $display("FAIL t5_abort_time: cycles=%0d want 256", n);
    end
    tick();
    n_tests++;
    if (frame_abort !== 1'b0) begin
      n_fail++; $display("FAIL t5_abort_width: got %b want 0", frame_abort);
    end
    base = log_mosi.size();
    send(1, 8'h51, 1'b1);
    wait_quiet(ok);
    n_tests++;
    if (!ok || log_mosi.size() != base + 1 || log_mosi[base] !== 8'h51) begin
      n_fail++; $display("FAIL t5_after_abort: done=%0d bytes=%0d want 51", ok, log_mosi.size() - base);
    end
  endtask
`endif

  task automatic test_reset_mid_op();
    int base; bit ok; bit seen;
    send(1, 8'h60, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (spi_bus.start[0]) begin seen = 1'b1; break; end
      tick();
    end
    tick(); tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (!seen || req_bus.busy !== 4'b0000 || req_bus.miso !== 8'h00 || spi_bus.start[0] !== 1'b0 ||
        spi_bus.mosi !== 8'h00 || spi_bus.cs_end[0] !== 1'b0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL t6_reset_outputs: seen=%0d busy=%b miso=%h start=%b mosi=%h cs_end=%b want all 0",
                         seen, req_bus.busy, req_bus.miso, spi_bus.start, spi_bus.mosi, spi_bus.cs_end);
    end
    tick(); tick();
    rst_n = 1'b1;
    wait_quiet(ok);
    miso_q.push_back(8'h77);
    base = log_mosi.size();
    send(1, 8'h61, 1'b1);
    wait_quiet(ok);
    n_tests++;
    if (!ok || log_mosi.size() != base + 1 || log_mosi[base] !== 8'h61 || req_bus.miso !== 8'h77) begin
      n_fail++; $display("FAIL t6_recover: done=%0d bytes=%0d miso=%h want 61/77", ok, log_mosi.size() - base, req_bus.miso);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_frame_lock();
    test_overrun();
`ifdef TDC_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
